// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache between fetch and memory.
// Cached mode gives zero-latency hits; bypass mode is a combinational pass-through.
//
// Ports:
//   clk, rst_b           clock (rising edge), async active-low reset
//   pc                   fetch address (word aligned)
//   cache_en             1 = cached, 0 = bypass to memory
//   inv                  synchronous invalidate-all pulse
//   inst, hit            instruction for pc, valid flag in cached mode
//   mem_req, mem_addr    line-fill request / word address
//   mem_rdata, mem_ack   memory read data, one word per ack
//   miss_cnt             saturating miss counter
module inst_cache #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] pc,
  input  logic        cache_en,
  input  logic        inv,
  output logic [31:0] inst,
  output logic        hit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] miss_cnt
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - OFF_W - IDX_W - 2;
  localparam int TAG_L = OFF_W + IDX_W + 2;
  localparam logic [OFF_W-1:0] LAST_W =
    OFF_W'(LINE_WORDS - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag_arr [NUM_LINES];
  logic [31:0]          r_data [NUM_LINES*LINE_WORDS];

  logic [IDX_W-1:0] r_lat_idx;
  logic [TAG_W-1:0] r_lat_tag;
  logic [OFF_W-1:0] r_cnt;
  logic [15:0]      r_miss;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_match;
  logic             w_last;
  logic             w_start;
  logic             w_wr;
  logic             w_done;

  assign w_off = pc[OFF_W+1:2];
  assign w_idx = pc[TAG_L-1:OFF_W+2];
  assign w_tag = pc[31:TAG_L];

  assign w_match = r_valid[w_idx] &&
                   (r_tag_arr[w_idx] == w_tag);
  assign w_last  = (r_cnt == LAST_W);

  assign miss_cnt = r_miss;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt    = r_state;
    w_start  = 1'b0;
    w_wr     = 1'b0;
    w_done   = 1'b0;
    hit      = 1'b0;
    inst     = '0;
    mem_req  = 1'b0;
    mem_addr = pc;
    if (!cache_en) begin
      inst = mem_rdata;
      if (r_state == FILL) begin
        w_nxt = IDLE;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          hit = w_match && !inv;
          if (hit) begin
            inst = r_data[{w_idx, w_off}];
          end
          if (!w_match && !inv) begin
            w_start = 1'b1;
            w_nxt   = FILL;
          end
        end
        FILL: begin
          mem_req  = 1'b1;
          // Fill address comes only from latched
          // state so pc may wander during the fill.
          mem_addr = {r_lat_tag, r_lat_idx,
                      r_cnt, 2'b00};
          if (inv) begin
            w_nxt = IDLE;
          end else if (mem_ack) begin
            w_wr = 1'b1;
            if (w_last) begin
              w_done = 1'b1;
              w_nxt  = IDLE;
            end
          end
        end
        default: begin
          w_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_valid   <= '0;
      r_cnt     <= '0;
      r_lat_idx <= '0;
      r_lat_tag <= '0;
      r_miss    <= '0;
    end else begin
      if (inv) begin
        r_valid <= '0;
      end else begin
        // Old line dies on fill entry so a
        // half-written line is never a hit.
        if (w_start) begin
          r_valid[w_idx] <= 1'b0;
        end
        if (w_done) begin
          r_valid[r_lat_idx] <= 1'b1;
        end
      end
      if (w_start) begin
        r_lat_idx <= w_idx;
        r_lat_tag <= w_tag;
        r_cnt     <= '0;
        if (r_miss != 16'hFFFF) begin
          r_miss <= r_miss + 16'd1;
        end
      end else if (w_wr) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_data[{r_lat_idx, r_cnt}] <= mem_rdata;
    end
    if (w_done) begin
      r_tag_arr[r_lat_idx] <= r_lat_tag;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Testbench for inst_cache: directed scenarios plus random fetches
// checked against a line-level model of the cache contents.
module tb_inst_cache;

  localparam int LW = 4;
  localparam int NL = 8;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] pc;
  logic        cache_en;
  logic        inv;
  logic [31:0] inst;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] miss_cnt;

  int n_chk = 0;
  int n_err = 0;
  int lat   = 2;

  logic        r_byp     = 1'b0;
  logic [31:0] bp_data   = '0;
  logic        resp_ack  = 1'b0;
  logic [31:0] resp_data = '0;

  bit          m_valid [NL];
  int unsigned m_tag   [NL];
  int          m_miss;

  assign mem_rdata = r_byp ? bp_data : resp_data;
  assign mem_ack   = resp_ack;

  inst_cache #(
    .LINE_WORDS(LW),
    .NUM_LINES (NL)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .pc       (pc),
    .cache_en (cache_en),
    .inv      (inv),
    .inst     (inst),
    .hit      (hit),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(
    input logic [31:0] a);
    return a ^ 32'hA5A50000;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / (4 * LW)) % NL);
  endfunction

  function automatic int unsigned m_tg(
    input logic [31:0] a);
    return a / (4 * LW * NL);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic count_miss();
    if (m_miss < 65535) m_miss++;
  endtask

  // Memory: each requested word is acked after
  // lat cycles with data derived from its address.
  initial begin
    int wc;
    wc = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        wc++;
        if (wc >= lat) begin
          resp_ack  = 1'b1;
          resp_data = word(mem_addr);
          wc = 0;
        end else begin
          resp_ack = 1'b0;
        end
      end else begin
        resp_ack = 1'b0;
        wc = 0;
      end
    end
  end

  task automatic wait_acks(input logic [31:0] a,
                           input int n);
    logic [31:0] base;
    int w;
    int g;
    base = a & ~32'(4 * LW - 1);
    w = 0;
    g = 0;
    while (w < n && g < 100) begin
      @(negedge clk);
      #1;
      g++;
      if (mem_ack) begin
        chk("fill_addr", mem_addr,
            base + 32'(4 * w));
        w++;
      end
    end
    chk("fill_acks", 32'(w), 32'(n));
  endtask

  task automatic fill_wait(input logic [31:0] a);
    wait_acks(a, LW);
    @(negedge clk);
    #1;
    chk("post_req",  32'(mem_req), 32'd0);
    chk("post_hit",  32'(hit), 32'd1);
    chk("post_inst", inst, word(a));
    chk("post_miss", 32'(miss_cnt), 32'(m_miss));
    m_valid[m_idx(a)] = 1'b1;
    m_tag[m_idx(a)]   = m_tg(a);
  endtask

  task automatic fetch(input logic [31:0] a);
    @(negedge clk);
    cache_en = 1'b1;
    r_byp    = 1'b0;
    inv      = 1'b0;
    pc       = a;
    #1;
    if (m_valid[m_idx(a)] &&
        m_tag[m_idx(a)] == m_tg(a)) begin
      chk("hit",      32'(hit), 32'd1);
      chk("hit_inst", inst, word(a));
      chk("hit_req",  32'(mem_req), 32'd0);
      chk("hit_miss", 32'(miss_cnt), 32'(m_miss));
    end else begin
      chk("miss_hit",  32'(hit), 32'd0);
      chk("miss_inst", inst, 32'd0);
      count_miss();
      fill_wait(a);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [31:0] a;
    rst_b    = 1'b0;
    cache_en = 1'b1;
    inv      = 1'b0;
    pc       = 32'h10;
    m_miss   = 0;
    model_clear();
    #1;
    chk("rst_hit",  32'(hit), 32'd0);
    chk("rst_req",  32'(mem_req), 32'd0);
    chk("rst_miss", 32'(miss_cnt), 32'd0);
    repeat (2) @(negedge clk);
    cache_en = 1'b0;
    rst_b    = 1'b1;

    // First fill, then same-line hits
    fetch(32'h10);
    fetch(32'h14);
    fetch(32'h1C);
    chk("miss_after_hits", 32'(miss_cnt), 32'd1);

    // Aliasing on index 1
    fetch(32'h90);
    fetch(32'h10);
    chk("alias_miss", 32'(miss_cnt), 32'd3);

    // Bypass: pass-through, no state change
    @(negedge clk);
    cache_en = 1'b0;
    r_byp    = 1'b1;
    bp_data  = 32'hDEADBEEF;
    pc       = 32'h40;
    #1;
    chk("byp_addr", mem_addr, 32'h40);
    chk("byp_inst", inst, 32'hDEADBEEF);
    chk("byp_hit",  32'(hit), 32'd0);
    chk("byp_req",  32'(mem_req), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("byp_miss", 32'(miss_cnt), 32'd3);
    fetch(32'h14);

    // Invalidate during fill at cnt=2
    @(negedge clk);
    pc = 32'h30;
    #1;
    chk("inv_miss", 32'(hit), 32'd0);
    count_miss();
    wait_acks(32'h30, 2);
    @(negedge clk);
    inv = 1'b1;
    #1;
    chk("inv_hit", 32'(hit), 32'd0);
    @(negedge clk);
    inv = 1'b0;
    #1;
    chk("inv_req",  32'(mem_req), 32'd0);
    chk("inv_idle", 32'(hit), 32'd0);
    model_clear();
    count_miss();
    fill_wait(32'h30);
    fetch(32'h10);

    // cache_en drops mid-fill
    @(negedge clk);
    pc = 32'h50;
    #1;
    chk("en_miss", 32'(hit), 32'd0);
    count_miss();
    wait_acks(32'h50, 1);
    @(negedge clk);
    cache_en = 1'b0;
    #1;
    chk("en_off_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    cache_en = 1'b1;
    #1;
    chk("en_no_partial", 32'(hit), 32'd0);
    chk("en_idle_req", 32'(mem_req), 32'd0);
    count_miss();
    fill_wait(32'h50);

    // Reset mid-fill with an ack pending
    @(negedge clk);
    pc = 32'h60;
    #1;
    count_miss();
    g = 0;
    while (!mem_ack && g < 20) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("rst_ack_seen", 32'(mem_ack), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("rst_mid_req",  32'(mem_req), 32'd0);
    chk("rst_mid_miss", 32'(miss_cnt), 32'd0);
    @(negedge clk);
    cache_en = 1'b0;
    rst_b    = 1'b1;
    m_miss   = 0;
    model_clear();
    fetch(32'h10);
    chk("rst_restart", 32'(miss_cnt), 32'd1);

    // Random fetches over a few tags
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        inv = 1'b1;
        #1;
        chk("rnd_inv_hit", 32'(hit), 32'd0);
        model_clear();
      end
      lat = int'($urandom_range(1, 3));
      a = 32'($urandom_range(0, 3)) * (4 * LW * NL)
        + 32'($urandom_range(0, NL - 1)) * (4 * LW)
        + 32'($urandom_range(0, LW - 1)) * 4;
      fetch(a);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and instruction memory.
- Takes the fetch PC and returns `inst` plus `hit`. The fetch stage advances its PC only when `!cache_en || hit`.
- On a miss, it fills one whole line from memory over a request/acknowledge port, then serves the fetch.
- When `cache_en=0`, it is a transparent combinational pass-through to memory.

Parameters:
- LINE_WORDS, 4: 32-bit words per line; must be a power of 2, ≥2.
- NUM_LINES, 8: number of lines; must be a power of 2, ≥2.
- OFF_W, log2(LINE_WORDS): word-offset bits (derived, not user-set).
- IDX_W, log2(NUM_LINES): index bits (derived, not user-set).

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- pc  in  32  fetch address, word aligned; pc[1:0] ignored.
- cache_en  in  1  1 = cached mode; 0 = bypass mode.
- inv  in  1  synchronous invalidate-all pulse.
- inst  out  32  instruction for pc.
- hit  out  1  inst is valid this cycle (cached mode).
- mem_req  out  1  line-fill read request, held until ack.
- mem_addr  out  32  memory word address.
- mem_rdata  in  32  memory read data.
- mem_ack  in  1  mem_rdata is valid for the current mem_addr; one word per ack.
- miss_cnt  out  16  count of misses, saturating.

Behaviour:
- Address split:
  - offset = pc[OFF_W+1:2]
  - index = pc[OFF_W+IDX_W+1:OFF_W+2]
  - tag = pc[31:OFF_W+IDX_W+2]
- Storage per line: valid bit, tag, LINE_WORDS data words.
- Reset (async, rst_b=0): all valid bits clear, state=IDLE, fill counter=0, mem_req=0, miss_cnt=0. Data and tag arrays are not reset.
- Lookup is combinational: match = valid[index] && tag_arr[index]==tag.
- Bypass mode (cache_en=0):
  - mem_addr=pc, inst=mem_rdata, hit=0, mem_req=0.
  - No state change, no counting.
  - Memory is treated as a zero-latency read port in this mode.
- Cached mode, outputs:
  - hit = (state==IDLE) && match.
  - inst = data[index][offset] when hit; otherwise 0.
  - Hit latency is 0 cycles.
- States: IDLE, FILL.
- IDLE:
  - On cache_en && !match && !inv: latch line base = {pc[31:OFF_W+2], OFF_W+2 zero bits}, latched index and latched tag.
  - Same cycle: cnt=0, increment miss_cnt unless it is at 0xFFFF, go to FILL.
- FILL:
  - mem_req=1, mem_addr = base + (cnt<<2), driven from latched values only; pc changes are ignored.
  - On mem_ack: write mem_rdata to data[lat_index][cnt], cnt++.
  - On mem_ack with cnt==LINE_WORDS-1: write tag_arr[lat_index]=lat_tag, set valid[lat_index]=1, go to IDLE.
  - The next cycle re-evaluates the lookup (normally a hit). Miss penalty is LINE_WORDS acks + 1 cycle.
  - mem_req deasserts in the cycle after the final ack.
- mem_ack while not in FILL: ignored.
- The old line at lat_index is invalidated on entry to FILL, so a partial line is never visible.
- cache_en falls during FILL: abort at the next edge, go to IDLE, line stays invalid, no partial validation.
- inv=1:
  - Clears all valid bits at the next edge and aborts any fill to IDLE.
  - hit is forced to 0 in that cycle.
  - inv has priority over a fill completing in the same cycle.
- Reset mid-fill: immediate return to the reset state; mem_req drops asynchronously.
- Index aliasing: a fill to line i evicts the previous tag there; there is no other replacement policy.

Test Plan:
- Reset, cache_en=1, pc=0x00000010, memory word at address A returns A^0xA5A50000 after 2 cycles -> hit=0; mem_addr 0x10,0x14,0x18,0x1C in order; then hit=1, inst=0xA5A50010, miss_cnt=1.
- After the first test, pc=0x14 then 0x1C -> hit=1 in the same cycle, inst=0xA5A50014 and 0xA5A5001C, no mem_req, miss_cnt stays 1.
- pc=0x90 (same index 1 as 0x10, different tag) -> miss and fill of 0x90..0x9C; then pc=0x10 -> miss again, miss_cnt=3.
- Assert inv during FILL at cnt=2 -> next cycle state IDLE, mem_req=0; re-present pc -> full refill starting at cnt=0, no hit on stale data.
- cache_en=0, pc=0x40, mem_rdata=0xDEADBEEF -> mem_addr=0x40, inst=0xDEADBEEF, hit=0, mem_req=0; miss_cnt unchanged.
- Pull rst_b low mid-fill with a pending ack -> mem_req=0 immediately; after release, pc=0x10 misses (valid cleared) and miss_cnt restarts at 1.
